seg7_frame_reader: RTL and testbench

Reads a time-multiplexed, active-low 4-digit seven-segment bus and recovers the displayed 16-bit hex value. It inverts the team's hex-to-segment mapping, so the same glyph table drives both directions. It is used as an on-board loopback checker and observer for display-driving blocks such as the counters. Each digit pattern is debounced, decoded back to a nibble and assembled into a frame, and the block then emits a one-cycle `valid` strobe with per-digit error flags.

---
 rtl/seg7_frame_reader.sv | 119 +++++++++++
 tb/tb_seg7_frame_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_reader.sv
// Observes an active-low, time-multiplexed 4-digit seven-segment bus and
// rebuilds the displayed 16-bit hex value, one debounced digit at a time.
module seg7_frame_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_n,
    output logic [15:0] value,
    output logic        valid,
    output logic [3:0]  digit_err,
    output logic        err
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SAMPLE_W = 11;

    logic [SAMPLE_W-1:0] smp;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          seen;
    logic [3:0]          bad;
    logic [15:0]         shadow;

    logic [SAMPLE_W-1:0] pins_c;
    logic [3:0]          sel_c;
    logic                one_hot_c;
    logic                accept_c;
    logic                commit_c;
    logic                legal_c;
    logic [3:0]          nib_c;
    logic [3:0]          seen_nx_c;
    logic [3:0]          bad_nx_c;
    logic [15:0]         shadow_nx_c;

    // Inverse of the hex-to-segment glyph table; MSB of the result flags a legal glyph.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = {1'b1, 4'h0};
            7'b1111001: decode = {1'b1, 4'h1};
            7'b0100100: decode = {1'b1, 4'h2};
            7'b0110000: decode = {1'b1, 4'h3};
            7'b0011001: decode = {1'b1, 4'h4};
            7'b0010010: decode = {1'b1, 4'h5};
            7'b0000010: decode = {1'b1, 4'h6};
            7'b1111000: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0010000: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b0000011: decode = {1'b1, 4'hB};
            7'b1000110: decode = {1'b1, 4'hC};
            7'b0100001: decode = {1'b1, 4'hD};
            7'b0000110: decode = {1'b1, 4'hE};
            7'b0001110: decode = {1'b1, 4'hF};
            default:    decode = 5'b0_0000;
        endcase
    endfunction

    // Acceptance fires on the edge where the run of identical samples reaches STABLE_CYCLES.
    always_comb begin
        pins_c    = {dig_n, seg_n};
        sel_c     = ~smp[10:7];
        one_hot_c = (sel_c != 4'd0) && ((sel_c & (sel_c - 4'd1)) == 4'd0);
        accept_c  = one_hot_c && (pins_c == smp) && (cnt == CNT_W'(STABLE_CYCLES - 1));
        commit_c  = (seen == 4'hF);
        {legal_c, nib_c} = decode(smp[6:0]);
    end

    // A commit clears the frame first, so a same-cycle acceptance lands in the new frame.
    always_comb begin
        seen_nx_c   = commit_c ? 4'd0 : seen;
        bad_nx_c    = commit_c ? 4'd0 : bad;
        shadow_nx_c = shadow;
        if (accept_c) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_c[i]) begin
                    seen_nx_c[i] = 1'b1;
                    if (legal_c) begin
                        shadow_nx_c[4*i +: 4] = nib_c;
                        bad_nx_c[i]           = 1'b0;
                    end else begin
                        bad_nx_c[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp       <= '1;
            cnt       <= '0;
            seen      <= '0;
            bad       <= '0;
            shadow    <= '0;
            value     <= '0;
            valid     <= 1'b0;
            digit_err <= '0;
            err       <= 1'b0;
        end else begin
            smp <= pins_c;
            if (pins_c != smp) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
                cnt <= cnt + CNT_W'(1);
            end
            seen   <= seen_nx_c;
            bad    <= bad_nx_c;
            shadow <= shadow_nx_c;
            valid  <= commit_c;
            if (commit_c) begin
                value     <= shadow;
                digit_err <= bad;
                err       <= |bad;
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Directed and randomized scans of seg7_frame_reader, checked against a
// run-length/event model of digit acceptance and frame assembly.
module tb_seg7_frame_reader;

    localparam int unsigned S = 4;

    typedef struct packed {
        logic [31:0] e;
        logic [15:0] v;
        logic [3:0]  de;
        logic        er;
    } commit_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = '1;
    logic [3:0]  dig_n = '1;
    logic [15:0] value;
    logic        valid;
    logic [3:0]  digit_err;
    logic        err;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int      passes = 0;
    int      total  = 0;
    int      cyc    = 0;
    int      dbl    = 0;
    int      last_valid_cyc = 0;
    logic    prev_valid = 1'b0;
    commit_t obs_q[$];
    commit_t exp_q[$];

    logic [3:0]  m_seen;
    logic [3:0]  m_bad;
    logic [15:0] m_shadow;
    bit          m_pend;
    int          m_pc;
    logic [10:0] pp;
    int          run;
    int          last_end;
    int          last_k;
    int          k3;

    seg7_frame_reader #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .dig_n     (dig_n),
        .value     (value),
        .valid     (valid),
        .digit_err (digit_err),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every commit seen on the outputs.
    always @(negedge clk) begin
        if (valid) begin
            obs_q.push_back(commit_t'{e: 32'(cyc), v: value, de: digit_err, er: err});
            last_valid_cyc <= cyc;
            if (prev_valid) dbl <= dbl + 1;
        end
        prev_valid <= valid;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    function automatic int decode_tb(input logic [6:0] p);
        int r;
        r = -1;
        for (int i = 0; i < 16; i++) if (glyph[i] == p) r = i;
        return r;
    endfunction

    function automatic bit is_onehot(input logic [3:0] dn);
        return $countones(~dn) == 1;
    endfunction

    task automatic model_commit();
        exp_q.push_back(commit_t'{e: 32'(m_pc), v: m_shadow, de: m_bad, er: |m_bad});
        m_seen = '0;
        m_bad  = '0;
        m_pend = 1'b0;
    endtask

    task automatic model_accept(input int e, input logic [10:0] pat);
        int d;
        int n;
        if (m_pend && m_pc <= e) model_commit();
        d = 0;
        for (int i = 0; i < 4; i++) if (!pat[7+i]) d = i;
        n = decode_tb(pat[6:0]);
        m_seen[d] = 1'b1;
        if (n >= 0) begin
            m_shadow[4*d +: 4] = 4'(n);
            m_bad[d] = 1'b0;
        end else begin
            m_bad[d] = 1'b1;
        end
        if (m_seen == 4'hF) begin
            m_pend = 1'b1;
            m_pc   = e + 1;
        end
    endtask

    // Pattern pat present for edges k..k+h-1; accepted once its run first spans S edges.
    task automatic model_hold(input logic [10:0] pat, input int k, input int h);
        int base;
        base = (pat == pp) ? run : 0;
        if (is_onehot(pat[10:7]) && base < int'(S) && base + h >= int'(S))
            model_accept(k + int'(S) - base - 1, pat);
        pp       = pat;
        run      = (base + h > 1000) ? 1000 : base + h;
        last_end = k + h - 1;
    endtask

    task automatic model_sync();
        if (cyc > last_end) model_hold(pp, last_end + 1, cyc - last_end);
    endtask

    task automatic drive(input logic [3:0] d, input logic [6:0] s, input int h);
        int k;
        @(negedge clk);
        dig_n = d;
        seg_n = s;
        k = cyc + 1;
        if (k - 1 > last_end) model_hold(pp, last_end + 1, k - 1 - last_end);
        model_hold({d, s}, k, h);
        last_k = k;
        repeat (h) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        dig_n = '1;
        seg_n = '1;
        model_sync();
        if (m_pend && m_pc <= cyc) model_commit();
        #2 rst = 1'b1;
        #1;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_digit_err", 32'(digit_err), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        m_seen = '0; m_bad = '0; m_shadow = '0; m_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pp = '1; run = 1000; last_end = cyc;
    endtask

    task automatic check_commits(input string tag);
        commit_t o;
        commit_t e;
        @(negedge clk);
        #1;
        model_sync();
        if (m_pend && m_pc <= cyc) model_commit();
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_edge"}, o.e, e.e);
            chk({tag, "_value"}, 32'(o.v), 32'(e.v));
            chk({tag, "_digit_err"}, 32'(o.de), 32'(e.de));
            chk({tag, "_err"}, 32'(o.er), 32'(e.er));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int r;
        logic [3:0] d;
        logic [6:0] s;
        logic [3:0] multi [4] = '{4'b1111, 4'b1100, 4'b0000, 4'b1010};

        m_seen = '0; m_bad = '0; m_shadow = '0; m_pend = 1'b0; m_pc = 0;
        pp = '1; run = 1000; last_end = 0; last_k = 0; k3 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_end = cyc;
        #1;
        chk("init_value", 32'(value), 32'h0);
        chk("init_valid", 32'(valid), 32'h0);
        chk("init_digit_err", 32'(digit_err), 32'h0);
        chk("init_err", 32'(err), 32'h0);

        // Normal frame 1,2,A,F
        drive(4'b1110, glyph[1], 6);
        drive(4'b1101, glyph[2], 6);
        drive(4'b1011, glyph[10], 6);
        drive(4'b0111, glyph[15], 6);
        k3 = last_k;
        drive(4'b1111, 7'h7F, 6);
        check_commits("frame");
        chk("frame_valid_edge", 32'(last_valid_cyc), 32'(k3 + int'(S)));
        chk("frame_value", 32'(value), 32'hFA21);
        chk("frame_err", 32'(err), 32'h0);
        chk("frame_digit_err", 32'(digit_err), 32'h0);

        // Partial frame discarded by an asynchronous reset
        drive(4'b1110, glyph[3], 6);
        drive(4'b1101, glyph[4], 6);
        drive(4'b1011, glyph[5], 6);
        do_reset();
        drive(4'b0111, glyph[6], 6);
        drive(4'b1111, 7'h7F, 6);
        check_commits("rst_partial");
        chk("rst_partial_value", 32'(value), 32'h0);

        // Debounce: fast toggles on digit 1 never land, a long hold lands once
        drive(4'b1110, glyph[0], 6);
        drive(4'b1011, glyph[2], 6);
        drive(4'b0111, glyph[3], 6);
        for (int i = 0; i < 10; i++) drive(4'b1101, (i % 2 == 1) ? glyph[8] : glyph[3], 3);
        drive(4'b1101, glyph[5], 100);
        drive(4'b1111, 7'h7F, 6);
        check_commits("deb1");
        chk("deb1_value", 32'(value), 32'h3250);
        drive(4'b1110, glyph[4], 6);
        drive(4'b1011, glyph[6], 6);
        drive(4'b0111, glyph[7], 6);
        drive(4'b1111, 7'h7F, 6);
        check_commits("deb2");
        drive(4'b1101, glyph[9], 6);
        drive(4'b1111, 7'h7F, 6);
        check_commits("deb3");
        chk("deb3_value", 32'(value), 32'h7694);

        // Illegal glyph on digit 2 keeps the old shadow nibble
        drive(4'b1110, glyph[1], 6);
        drive(4'b1101, glyph[2], 6);
        drive(4'b1011, 7'h7F, 6);
        drive(4'b0111, glyph[4], 6);
        drive(4'b1111, 7'h7F, 6);
        check_commits("ill");
        chk("ill_value", 32'(value), 32'h4621);
        chk("ill_digit_err", 32'(digit_err), 32'h4);
        chk("ill_err", 32'(err), 32'h1);
        drive(4'b1110, glyph[8], 6);
        drive(4'b1101, glyph[9], 6);
        drive(4'b1011, glyph[10], 6);
        drive(4'b0111, glyph[11], 6);
        drive(4'b1111, 7'h7F, 6);
        check_commits("clean");
        chk("clean_value", 32'(value), 32'hBA98);
        chk("clean_digit_err", 32'(digit_err), 32'h0);
        chk("clean_err", 32'(err), 32'h0);

        // Multi-select and blank are ignored; last acceptance of digit 3 wins
        drive(4'b0111, glyph[7], 6);
        drive(4'b1100, glyph[0], 20);
        drive(4'b1110, glyph[12], 6);
        drive(4'b1111, 7'h7F, 20);
        drive(4'b0111, glyph[9], 6);
        drive(4'b1101, glyph[13], 6);
        drive(4'b1011, glyph[14], 6);
        drive(4'b1111, 7'h7F, 6);
        check_commits("multi");
        chk("multi_value", 32'(value), 32'h9EDC);

        // Back-to-back frames at minimum hold; next frame's digit 0 overlaps the commit
        for (int i = 0; i < 4; i++) drive(~(4'b0001 << i), glyph[2*i+1], S);
        for (int i = 0; i < 4; i++) drive(~(4'b0001 << i), glyph[2*i+2], S);
        drive(4'b1111, 7'h7F, 8);
        @(negedge clk);
        #1;
        chk("b2b_count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            chk("b2b_gap", obs_q[1].e - obs_q[0].e, 32'(4 * S));
            chk("b2b_first", 32'(obs_q[0].v), 32'h7531);
            chk("b2b_second", 32'(obs_q[1].v), 32'h8642);
        end
        check_commits("b2b");

        // Randomized scanning against the model
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else begin
                if (r < 90) d = ~(4'b0001 << $urandom_range(0, 3));
                else d = multi[$urandom_range(0, 3)];
                if ($urandom_range(0, 7) == 0) s = 7'($urandom);
                else s = glyph[$urandom_range(0, 15)];
                drive(d, s, int'($urandom_range(1, 2 * S + 2)));
            end
            if (n % 50 == 49) begin
                drive(4'b1111, 7'h7F, 10);
                check_commits("rnd");
            end
        end

        chk("no_double_valid", 32'(dbl), 32'h0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
